// File: rtl/band_cal_pkg.sv
// Shared types, defaults and gray decode for the DPLL coarse-band calibrator.
// Optional final-frequency verify is enabled with BAND_CAL_TOL_CHK_EN.
package band_cal_pkg;

    localparam int BAND_W         = 8;
    localparam int SETTLE_CYC_DEF = 64;
    localparam int WIN_CYC_DEF    = 256;
    localparam int TOL_CNT_DEF    = 8;

    typedef logic [2:0] cal_state_t;

    localparam cal_state_t ST_IDLE   = 3'd0;
    localparam cal_state_t ST_SETTLE = 3'd1;
    localparam cal_state_t ST_MEAS   = 3'd2;
    localparam cal_state_t ST_DECIDE = 3'd3;
    localparam cal_state_t ST_VERIFY = 3'd4;
    localparam cal_state_t ST_DONE   = 3'd5;

    // Works for any width up to 32: zero-extended upper gray bits decode to zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/band_cal_ctrl_gray_cnt_cap.sv
// Gray decode of the DCO edge counter with start/end snapshots.
// delta is the modular window count, so counter wrap needs no special case.
module gray_cnt_cap
    import band_cal_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_gray,
    input  logic             cap_start,
    input  logic             cap_end,
    output logic [CNT_W-1:0] delta
);

    logic [CNT_W-1:0] cnt_bin;
    logic [CNT_W-1:0] start_q, start_d;
    logic [CNT_W-1:0] end_q, end_d;

    always_comb begin
        cnt_bin = CNT_W'(gray2bin(32'(cnt_gray)));
        start_d = cap_start ? cnt_bin : start_q;
        end_d   = cap_end ? cnt_bin : end_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
            end_q   <= '0;
        end else begin
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign delta = end_q - start_q;

endmodule

// File: rtl/band_cal_ctrl.sv
// Coarse-band SAR acquisition sequencer for the DPLL DCO (ref_clk domain).
// Define BAND_CAL_TOL_CHK_EN to add a final verify window that drives cal_err.
module band_cal_ctrl
    import band_cal_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int WIN_CYC    = WIN_CYC_DEF
`ifdef BAND_CAL_TOL_CHK_EN
    ,
    parameter int TOL_CNT    = TOL_CNT_DEF
`endif
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              csr_cal_en,
    input  logic              csr_cal_start,
    input  logic [BAND_W-1:0] csr_band_man,
    input  logic [CNT_W-1:0]  csr_target_cnt,
    input  logic [CNT_W-1:0]  dco_cnt_gray,
    output logic [BAND_W-1:0] band,
    output logic              dlf_hold,
    output logic              cal_busy,
    output logic              cal_done,
    output logic              cal_err
);

    localparam int TMR_W = $clog2(SETTLE_CYC + WIN_CYC + 1);
    localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WIN_CYC - 1);

    cal_state_t        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [BAND_W-1:0] trial_q, trial_d;
    logic [2:0]        iter_q, iter_d;
    logic              cap_start, cap_end, too_fast;
    logic [CNT_W-1:0]  delta;

    gray_cnt_cap #(.CNT_W(CNT_W)) u_cap (
        .clk       (ref_clk),
        .rst       (rst),
        .cnt_gray  (dco_cnt_gray),
        .cap_start (cap_start),
        .cap_end   (cap_end),
        .delta     (delta)
    );

`ifdef BAND_CAL_TOL_CHK_EN
    // Verify runs settle and window back to back, then judges one cycle later.
    localparam logic [TMR_W-1:0] VER_END  = TMR_W'(SETTLE_CYC + WIN_CYC - 1);
    localparam logic [TMR_W-1:0] VER_LAST = TMR_W'(SETTLE_CYC + WIN_CYC);
    logic             err_q, err_d, out_of_tol;
    logic [CNT_W-1:0] diff;

    always_comb begin
        diff = (delta >= csr_target_cnt) ? delta - csr_target_cnt
                                         : csr_target_cnt - delta;
        out_of_tol = diff > CNT_W'(TOL_CNT);
    end
    assign cal_err = err_q;
`else
    assign cal_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        trial_d   = trial_q;
        iter_d    = iter_q;
        cap_start = 1'b0;
        cap_end   = 1'b0;
        too_fast  = delta > csr_target_cnt;
`ifdef BAND_CAL_TOL_CHK_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (csr_cal_start) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                    trial_d = 8'h80;
                    iter_d  = '0;
`ifdef BAND_CAL_TOL_CHK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_SETTLE: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == SET_LAST) begin
                    cap_start = 1'b1;
                    tmr_d     = '0;
                    state_d   = ST_MEAS;
                end
            end
            ST_MEAS: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == WIN_LAST) begin
                    cap_end = 1'b1;
                    tmr_d   = '0;
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                tmr_d = '0;
                if (too_fast) trial_d[3'd7 - iter_q] = 1'b0;
                if (iter_q != 3'd7) begin
                    trial_d[3'd6 - iter_q] = 1'b1;
                    iter_d  = iter_q + 1'b1;
                    state_d = ST_SETTLE;
                end else begin
`ifdef BAND_CAL_TOL_CHK_EN
                    state_d = ST_VERIFY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef BAND_CAL_TOL_CHK_EN
            ST_VERIFY: begin
                tmr_d     = tmr_q + 1'b1;
                cap_start = tmr_q == SET_LAST;
                cap_end   = tmr_q == VER_END;
                if (tmr_q == VER_LAST) begin
                    err_d   = out_of_tol;
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // Disable overrides everything, including a same-cycle start.
        if (!csr_cal_en) begin
            state_d = ST_IDLE;
`ifdef BAND_CAL_TOL_CHK_EN
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            trial_q <= '0;
            iter_q  <= '0;
`ifdef BAND_CAL_TOL_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            trial_q <= trial_d;
            iter_q  <= iter_d;
`ifdef BAND_CAL_TOL_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign band     = (state_q == ST_IDLE) ? csr_band_man : trial_q;
    assign cal_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign dlf_hold = cal_busy;
    assign cal_done = state_q == ST_DONE;

endmodule

// File: tb/tb_band_cal_ctrl.sv
// Scoreboard bench for band_cal_ctrl with a rate-model DCO counter.
// Expectations follow BAND_CAL_TOL_CHK_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_band_cal_ctrl;

    localparam int T = 64 + 256 + 1;
`ifdef BAND_CAL_TOL_CHK_EN
    localparam int DONE_LAT = 9 * T + 1;
    localparam bit TOL_ON   = 1'b1;
`else
    localparam int DONE_LAT = 8 * T + 1;
    localparam bit TOL_ON   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        csr_cal_en = 1'b0;
    logic        csr_cal_start = 1'b0;
    logic [7:0]  csr_band_man = 8'h3C;
    logic [15:0] csr_target_cnt = '0;
    logic [15:0] dco_cnt_gray;
    logic [7:0]  band;
    logic        dlf_hold, cal_busy, cal_done, cal_err;

    band_cal_ctrl dut (
        .ref_clk        (clk),
        .rst            (rst),
        .csr_cal_en     (csr_cal_en),
        .csr_cal_start  (csr_cal_start),
        .csr_band_man   (csr_band_man),
        .csr_target_cnt (csr_target_cnt),
        .dco_cnt_gray   (dco_cnt_gray),
        .band           (band),
        .dlf_hold       (dlf_hold),
        .cal_busy       (cal_busy),
        .cal_done       (cal_done),
        .cal_err        (cal_err)
    );

    always #5 clk = ~clk;

    // DCO model: 4*band+100 edges per 256 ref cycles, as a fixed-point accumulator.
    logic [31:0] acc = '0;
    logic [15:0] base = '0;
    logic [15:0] cnt_bin;
    assign cnt_bin = base + acc[23:8];
    assign dco_cnt_gray = cnt_bin ^ (cnt_bin >> 1);
    always @(negedge clk) acc = acc + 32'(4 * int'(band) + 100);

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] band;
        logic       err;
        int         t0;
    } exp_t;
    exp_t exp_q[$];

    int   done_cnt = 0;
    int   hold_bad = 0;
    logic done_d = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (cal_busy && !dlf_hold) hold_bad = hold_bad + 1;
        if (cal_done && !done_d) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("final_band", int'(band), int'(e.band));
                chk("final_err", int'(cal_err), int'(e.err));
                chk("done_latency", cyc - e.t0, DONE_LAT);
                chk("hold_in_done", int'(dlf_hold), 0);
            end
            done_cnt = done_cnt + 1;
        end
        done_d = cal_done;
    end

    task automatic do_start(input logic [15:0] tgt, input logic [7:0] eb,
                            input logic ee, input bit push);
        exp_t e;
        @(negedge clk);
        csr_target_cnt = tgt;
        csr_cal_start  = 1'b1;
        e.band = eb;
        e.err  = ee;
        e.t0   = cyc;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        csr_cal_start = 1'b0;
    endtask

    task automatic wait_done();
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < 4000 && done_cnt == n0; i++) @(negedge clk);
        if (done_cnt == n0) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_band"}, int'(band), int'(csr_band_man));
        chk({tag, "_hold"}, int'(dlf_hold), 0);
        chk({tag, "_busy"}, int'(cal_busy), 0);
        chk({tag, "_done"}, int'(cal_done), 0);
        chk({tag, "_err"}, int'(cal_err), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_idle("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        csr_cal_en = 1'b1;
        csr_band_man = 8'h5A;
        @(negedge clk);
        chk("idle_band_follow", int'(band), 'h5A);

        // Search converging on 0x80: band walks 80, C0->80, A0->80, ...
        do_start(16'd612, 8'h80, 1'b0, 1'b1);
        chk("start_band", int'(band), 'h80);
        chk("start_busy", int'(cal_busy), 1);
        chk("start_hold", int'(dlf_hold), 1);
        chk("start_done", int'(cal_done), 0);
        repeat (T) @(negedge clk);
        chk("trial2_band", int'(band), 'hC0);
        repeat (T) @(negedge clk);
        chk("trial3_band", int'(band), 'hA0);
        wait_done();
        repeat (5) @(negedge clk);
        chk("done_sticky", int'(cal_done), 1);
        chk("done_band_hold", int'(band), 'h80);

        hold_bad = 0;
        do_start(16'd1119, 8'hFE, 1'b0, 1'b1);
        wait_done();
        chk("hold_whole_search", hold_bad, 0);
        chk("busy_in_done", int'(cal_busy), 0);

        do_start(16'd50, 8'h00, TOL_ON, 1'b1);
        wait_done();

        // Rebase so the first start capture lands just below wrap.
        @(negedge clk);
        base = 16'hFFF0 - 16'd170 - acc[23:8];
        do_start(16'd612, 8'h80, 1'b0, 1'b1);
        wait_done();

        // Abort in the third trial.
        do_start(16'd612, 8'h80, 1'b0, 1'b0);
        repeat (2 * T + 100) @(negedge clk);
        chk("pre_abort_busy", int'(cal_busy), 1);
        csr_cal_en = 1'b0;
        @(negedge clk);
        chk_idle("abort");
        csr_cal_start = 1'b1;
        @(negedge clk);
        csr_cal_start = 1'b0;
        chk_idle("start_vs_abort");
        csr_cal_en = 1'b1;

        // Restart; a start pulse mid-search must not disturb it.
        do_start(16'd1119, 8'hFE, 1'b0, 1'b1);
        chk("restart_band", int'(band), 'h80);
        repeat (T) @(negedge clk);
        csr_target_cnt = 16'd612;
        csr_cal_start = 1'b1;
        @(negedge clk);
        csr_cal_start = 1'b0;
        csr_target_cnt = 16'd1119;
        wait_done();

        // Async reset in the middle of a window.
        do_start(16'd612, 8'h80, 1'b0, 1'b0);
        repeat (150) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_idle("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_idle("post_rst");
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
